// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencing controller.
// This Moore FSM steps each instruction through fetch, decode, execute,
// memory and writeback. It drives the datapath selects and strobes, stalls
// on mem_ready, and counts retired instructions.
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             op_code,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_source,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   arith,
  output logic [3:0]             state,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;
  logic [COUNT_WIDTH-1:0] r_count;

  // Un-gated strobes. They are masked by rst_n before they leave the block.
  logic w_pc_write;
  logic w_pc_write_cond;
  logic w_mem_read;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;
  logic w_instr_done;
  logic w_illegal_op;

  // State register. Reset, or an abandoned instruction, returns to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter. It wraps silently at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_instr_done) begin
      r_count <= r_count + COUNT_ONE;
    end
  end

  // Next-state logic and Moore outputs. Mealy exceptions: FETCH and memory
  // handshakes on mem_ready, and the DECODE illegal-opcode pulse.
  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    pc_source       = 2'b00;
    iord            = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    reg_dst         = 2'b00;
    mem_to_reg      = 2'b00;
    w_reg_write     = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        alu_src_b = 2'b11;
        case (op_code)
          OP_RTYPE:                 w_next = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:             w_next = S_MEM_ADDR;
          OP_BEQ:                   w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
          OP_J:                     w_next = S_JUMP;
          OP_JAL:                   w_next = S_JAL;
          default: begin
            w_illegal_op = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (op_code == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord       = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg   = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_dst      = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
        w_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        pc_source    = 2'b10;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        reg_dst      = 2'b10;
        mem_to_reg   = 2'b10;
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        pc_source    = 2'b10;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JR: begin
        w_pc_write   = 1'b1;
        pc_source    = 2'b11;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are held low for the whole time reset is asserted.
  assign pc_write      = w_pc_write      & rst_n;
  assign pc_write_cond = w_pc_write_cond & rst_n;
  assign mem_read      = w_mem_read      & rst_n;
  assign mem_write     = w_mem_write     & rst_n;
  assign ir_write      = w_ir_write      & rst_n;
  assign reg_write     = w_reg_write     & rst_n;
  assign instr_done    = w_instr_done    & rst_n;
  assign illegal_op    = w_illegal_op    & rst_n;

  assign arith       = !((op_code == OP_ANDI) || (op_code == OP_ORI));
  assign state       = r_state;
  assign instr_count = r_count;

endmodule
